// File: rtl/truth_sweep_checker.sv
// truth_sweep_checker: exhaustive truth-table sweeper for a small combinational
// block. It steps stim through every input vector, waits SETTLE cycles, samples
// dut_out and compares it against the packed EXPECT table. It reports pass/fail,
// the mismatch count and the first failing vector.
//
// Optional build macro: TRUTH_SWEEP_SIG_EN adds a CRC-16-CCITT signature
// output 'sig' that is accumulated over the sampled responses.
//
// Control semantics (start/busy/done):
//   start is a level request that is looked at only while the checker is idle.
//     A sweep begins on the first clock edge at which start=1 in IDLE.
//   busy is high from the edge after that start until the final sample edge.
//   done is a one-cycle pulse after a sweep that was not aborted.
//   abort cancels a running sweep and takes priority over a same-cycle sample.
//   No output depends combinationally on any input.
module truth_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = 16'h6996
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   fail_vec,
  output logic [N_OUT-1:0]  fail_got,
`ifdef TRUTH_SWEEP_SIG_EN
  output logic [15:0]       sig,
`endif
  output logic [1:0]        dbg_state
);

  // Reject illegal configurations at elaboration time.
  if (SETTLE < 1) begin : g_bad_settle
    $error("truth_sweep_checker: SETTLE must be >= 1");
  end
  if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
    $error("truth_sweep_checker: N_IN must be in 1..8");
  end
  if (N_OUT < 1 || N_OUT > 8) begin : g_bad_n_out
    $error("truth_sweep_checker: N_OUT must be in 1..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // The settle counter only has to reach SETTLE-1.
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam int              NVEC     = 2 ** N_IN;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN:0]     err_cnt_q, err_cnt_d;
  logic              fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
  logic [N_OUT-1:0]  fail_got_q, fail_got_d;
`ifdef TRUTH_SWEEP_SIG_EN
  logic [15:0]       sig_q, sig_d;
  logic [15:0]       sig_next;
`endif

  // The expected table is unpacked into one entry per vector. Indexing it with
  // stim then needs exactly N_IN index bits.
  logic [N_OUT-1:0] exp_tab [NVEC];
  for (genvar g = 0; g < NVEC; g++) begin : g_exp_tab
    assign exp_tab[g] = EXPECT[g*N_OUT +: N_OUT];
  end

  logic [N_OUT-1:0] exp_entry;
  logic             mismatch;
  assign exp_entry = exp_tab[stim_q];
  assign mismatch  = (dut_out != exp_entry);

`ifdef TRUTH_SWEEP_SIG_EN
  // Advance the CRC-16-CCITT by one step, then fold in the sampled response.
  always_comb begin
    sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000);
    sig_next = sig_next ^ {{(16-N_OUT){1'b0}}, dut_out};
  end
`endif

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stim_d       = stim_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    fail_got_d   = fail_got_q;
`ifdef TRUTH_SWEEP_SIG_EN
    sig_d        = sig_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SETTLE;
          cnt_d        = '0;
          stim_d       = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          err_cnt_d    = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          fail_got_d   = '0;
`ifdef TRUTH_SWEEP_SIG_EN
          sig_d        = 16'hFFFF;
`endif
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          stim_d  = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // Abort wins over this sample, so the sample is dropped entirely.
          state_d = ST_IDLE;
          cnt_d   = '0;
          stim_d  = '0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = stim_q;
              fail_got_d   = dut_out;
            end
          end
`ifdef TRUTH_SWEEP_SIG_EN
          sig_d = sig_next;
`endif
          if (stim_q == LAST_VEC) begin
            // pass uses the final count, including this last sample.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end else begin
            state_d = ST_SETTLE;
            stim_d  = stim_q + 1'b1;
            cnt_d   = '0;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
`ifdef TRUTH_SWEEP_SIG_EN
      sig_q        <= 16'hFFFF;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      fail_got_q   <= fail_got_d;
`ifdef TRUTH_SWEEP_SIG_EN
      sig_q        <= sig_d;
`endif
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_got   = fail_got_q;
  assign dbg_state  = state_q;
`ifdef TRUTH_SWEEP_SIG_EN
  assign sig        = sig_q;
`endif

endmodule

// File: tb/tb_truth_sweep_checker.sv
// tb_truth_sweep_checker: drives three checker instances with different
// configurations. Each instance has a behavioural block under test that is
// modelled as a response table indexed by stim. Every expected result comes
// from a reference model that walks the whole table.
module tb_truth_sweep_checker;

  // Instance 0 "small": 2 inputs, 1 output, settle 1, XOR table.
  localparam int          S_NIN = 2, S_NOUT = 1, S_SET = 1;
  localparam logic [3:0]  S_EXP = 4'b0110;
  // Instance 1 "big": 4 inputs, 1 output, settle 3, 4-input XOR table.
  localparam int          B_NIN = 4, B_NOUT = 1, B_SET = 3;
  localparam logic [15:0] B_EXP = 16'h6996;
  // Instance 2 "wide": 3 inputs, 2 outputs, settle 2, arbitrary table.
  localparam int          W_NIN = 3, W_NOUT = 2, W_SET = 2;
  localparam logic [15:0] W_EXP = 16'hB4E1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic              s_start, s_abort, s_busy, s_done, s_pass, s_fv;
  logic [S_NIN-1:0]  s_stim, s_fvec;
  logic [S_NOUT-1:0] s_dut_out, s_fgot;
  logic [S_NIN:0]    s_err;
  logic [1:0]        s_dbg;
  logic [S_NOUT-1:0] s_resp [4];

  logic              b_start, b_abort, b_busy, b_done, b_pass, b_fv;
  logic [B_NIN-1:0]  b_stim, b_fvec;
  logic [B_NOUT-1:0] b_dut_out, b_fgot;
  logic [B_NIN:0]    b_err;
  logic [1:0]        b_dbg;
  logic [B_NOUT-1:0] b_resp [16];

  logic              w_start, w_abort, w_busy, w_done, w_pass, w_fv;
  logic [W_NIN-1:0]  w_stim, w_fvec;
  logic [W_NOUT-1:0] w_dut_out, w_fgot;
  logic [W_NIN:0]    w_err;
  logic [1:0]        w_dbg;
  logic [W_NOUT-1:0] w_resp [8];

`ifdef TRUTH_SWEEP_SIG_EN
  logic [15:0] s_sig, b_sig, w_sig;
`endif

  // Blocks under test: purely combinational lookups of stim.
  assign s_dut_out = s_resp[s_stim];
  assign b_dut_out = b_resp[b_stim];
  assign w_dut_out = w_resp[w_stim];

  truth_sweep_checker #(.N_IN(S_NIN), .N_OUT(S_NOUT), .SETTLE(S_SET), .EXPECT(S_EXP)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .stim(s_stim),
    .dut_out(s_dut_out), .busy(s_busy), .done(s_done), .pass(s_pass), .err_cnt(s_err),
    .fail_valid(s_fv), .fail_vec(s_fvec), .fail_got(s_fgot),
`ifdef TRUTH_SWEEP_SIG_EN
    .sig(s_sig),
`endif
    .dbg_state(s_dbg));

  truth_sweep_checker #(.N_IN(B_NIN), .N_OUT(B_NOUT), .SETTLE(B_SET), .EXPECT(B_EXP)) u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .stim(b_stim),
    .dut_out(b_dut_out), .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err),
    .fail_valid(b_fv), .fail_vec(b_fvec), .fail_got(b_fgot),
`ifdef TRUTH_SWEEP_SIG_EN
    .sig(b_sig),
`endif
    .dbg_state(b_dbg));

  truth_sweep_checker #(.N_IN(W_NIN), .N_OUT(W_NOUT), .SETTLE(W_SET), .EXPECT(W_EXP)) u_wide (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort), .stim(w_stim),
    .dut_out(w_dut_out), .busy(w_busy), .done(w_done), .pass(w_pass), .err_cnt(w_err),
    .fail_valid(w_fv), .fail_vec(w_fvec), .fail_got(w_fgot),
`ifdef TRUTH_SWEEP_SIG_EN
    .sig(w_sig),
`endif
    .dbg_state(w_dbg));

  int errors = 0;
  int checks = 0;

  // ---------------- helpers: clocking, driving, observing ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nvec(input int which);
    return (which == 0) ? 4 : (which == 1) ? 16 : 8;
  endfunction

  function automatic int per(input int which);
    return (which == 0) ? S_SET + 1 : (which == 1) ? B_SET + 1 : W_SET + 1;
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0: s_start = v;
      1: b_start = v;
      default: w_start = v;
    endcase
  endtask

  task automatic set_abort(input int which, input logic v);
    case (which)
      0: s_abort = v;
      1: b_abort = v;
      default: w_abort = v;
    endcase
  endtask

  task automatic peek(input int which, output int bsy, output int dn, output int st,
                      output int er, output int fv, output int fvec, output int fgot,
                      output int ps);
    case (which)
      0: begin bsy = int'(s_busy); dn = int'(s_done); st = int'(s_stim); er = int'(s_err);
               fv = int'(s_fv); fvec = int'(s_fvec); fgot = int'(s_fgot); ps = int'(s_pass); end
      1: begin bsy = int'(b_busy); dn = int'(b_done); st = int'(b_stim); er = int'(b_err);
               fv = int'(b_fv); fvec = int'(b_fvec); fgot = int'(b_fgot); ps = int'(b_pass); end
      default: begin bsy = int'(w_busy); dn = int'(w_done); st = int'(w_stim); er = int'(w_err);
               fv = int'(w_fv); fvec = int'(w_fvec); fgot = int'(w_fgot); ps = int'(w_pass); end
    endcase
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_entry(input int which, input int v);
    logic [15:0] t;
    logic [1:0]  e2;
    case (which)
      0: begin t = {12'd0, S_EXP}; return int'(t[v]); end
      1: begin t = B_EXP; return int'(t[v]); end
      default: begin t = W_EXP; e2 = t[v*2 +: 2]; return int'(e2); end
    endcase
  endfunction

  function automatic int get_resp(input int which, input int v);
    case (which)
      0: return int'(s_resp[v]);
      1: return int'(b_resp[v]);
      default: return int'(w_resp[v]);
    endcase
  endfunction

  // mode 0: correct block (XOR for the 1-output tables, table copy for wide)
  // mode 1: outputs stuck at 0; mode 2: random corruption of about 1/3 of vectors
  task automatic fill_resp(input int which, input int mode);
    int val;
    logic [7:0] vb;
    int nout;
    nout = (which == 2) ? W_NOUT : 1;
    for (int v = 0; v < nvec(which); v++) begin
      vb  = v[7:0];
      val = (which == 2) ? exp_entry(which, v) : int'(^vb);
      if (mode == 1) val = 0;
      if (mode == 2 && $urandom_range(0, 2) == 0) val = int'($urandom_range(0, (1 << nout) - 1));
      case (which)
        0: s_resp[v] = val[0];
        1: b_resp[v] = val[0];
        default: w_resp[v] = val[1:0];
      endcase
    end
  endtask

  // Mismatch statistics over the first 'upto' vectors of the sweep.
  task automatic model(input int which, input int upto, output int e_err,
                       output int e_first, output int e_got);
    e_err = 0; e_first = -1; e_got = 0;
    for (int v = 0; v < upto; v++) begin
      if (get_resp(which, v) != exp_entry(which, v)) begin
        e_err++;
        if (e_first < 0) begin e_first = v; e_got = get_resp(which, v); end
      end
    end
  endtask

  function automatic logic [15:0] crc_model(input int which);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int v = 0; v < nvec(which); v++) begin
      c = {c[14:0], 1'b0} ^ (c[15] ? 16'h1021 : 16'h0000);
      c = c ^ 16'(get_resp(which, v));
    end
    return c;
  endfunction

  // One sweep: pulse start, then watch until done. Cycle 1 is the first cycle
  // after the start edge. Returns busy cycle count, the cycle of the done pulse
  // (0 if the budget ran out) and the number of cycles whose stim value differed
  // from the vector that should be held.
  task automatic run_sweep(input int which, output int busy_n, output int done_cyc,
                           output int stim_bad);
    int bsy, dn, st, er, fv, fvec, fgot, ps, p;
    p = per(which);
    busy_n = 0; done_cyc = 0; stim_bad = 0;
    set_start(which, 1'b1);
    step();
    set_start(which, 1'b0);
    for (int c = 1; c <= nvec(which) * p + 20; c++) begin
      peek(which, bsy, dn, st, er, fv, fvec, fgot, ps);
      if (bsy == 1) begin
        busy_n++;
        if (st != (c - 1) / p) stim_bad++;
      end
      if (dn == 1) begin
        done_cyc = c;
        break;
      end
      step();
    end
  endtask

  // Compare the result registers of one instance against the model.
  task automatic check_results(input string tag, input int which, input int upto,
                               input int exp_pass);
    int bsy, dn, st, er, fv, fvec, fgot, ps, e_err, e_first, e_got;
    model(which, upto, e_err, e_first, e_got);
    peek(which, bsy, dn, st, er, fv, fvec, fgot, ps);
    checks++;
    if (er !== e_err) begin errors++; $display("FAIL %s err_cnt got=%0d exp=%0d", tag, er, e_err); end
    checks++;
    if (fv !== int'(e_first >= 0)) begin errors++; $display("FAIL %s fail_valid got=%0d exp=%0d", tag, fv, e_first >= 0); end
    if (e_first >= 0) begin
      checks++;
      if (fvec !== e_first || fgot !== e_got) begin
        errors++;
        $display("FAIL %s fail_vec/got got=%0d/%0d exp=%0d/%0d", tag, fvec, fgot, e_first, e_got);
      end
    end
    checks++;
    if (ps !== exp_pass) begin errors++; $display("FAIL %s pass got=%0d exp=%0d", tag, ps, exp_pass); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bsy, dn, st, er, fv, fvec, fgot, ps;
    for (int c = 0; c < 20; c++) begin
      for (int w = 0; w < 3; w++) begin
        peek(w, bsy, dn, st, er, fv, fvec, fgot, ps);
        checks++;
        if ((bsy | dn | st | er | fv | fvec | fgot | ps) !== 0) begin
          errors++;
          $display("FAIL reset inst%0d busy=%0d done=%0d stim=%0d err=%0d fv=%0d pass=%0d exp all 0",
                   w, bsy, dn, st, er, fv, ps);
        end
      end
`ifdef TRUTH_SWEEP_SIG_EN
      checks++;
      if (b_sig !== 16'hFFFF) begin errors++; $display("FAIL reset sig got=%h exp=ffff", b_sig); end
`endif
      step();
    end
  endtask

  task automatic test_pass_sweep();
    int busy_n, done_cyc, stim_bad;
    fill_resp(0, 0);
    run_sweep(0, busy_n, done_cyc, stim_bad);
    checks++;
    if (busy_n !== 8) begin errors++; $display("FAIL pass_sweep busy_cycles got=%0d exp=8", busy_n); end
    checks++;
    if (done_cyc !== 9) begin errors++; $display("FAIL pass_sweep done_cycle got=%0d exp=9", done_cyc); end
    checks++;
    if (stim_bad !== 0) begin errors++; $display("FAIL pass_sweep stim_sequence bad_cycles=%0d exp=0", stim_bad); end
    check_results("pass_sweep", 0, 4, 1);
    step();
    checks++;
    if (s_done !== 1'b0 || s_stim !== 2'd3 || s_pass !== 1'b1 || s_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%0d stim=%0d pass=%0d busy=%0d exp 0/3/1/0", s_done, s_stim, s_pass, s_busy);
    end
    // abort in IDLE has no effect on the held results
    s_abort = 1'b1; step(); s_abort = 1'b0;
    check_results("abort_idle", 0, 4, 1);
  endtask

  task automatic test_stuck();
    int busy_n, done_cyc, stim_bad;
    fill_resp(0, 1);
    run_sweep(0, busy_n, done_cyc, stim_bad);
    checks++;
    if (done_cyc !== 9) begin errors++; $display("FAIL stuck done_cycle got=%0d exp=9", done_cyc); end
    check_results("stuck", 0, 4, 0);
    checks++;
    if (s_err !== 3'd2 || s_fvec !== 2'd1 || s_fgot !== 1'b0) begin
      errors++; $display("FAIL stuck_values err=%0d fvec=%0d fgot=%0d exp 2/1/0", s_err, s_fvec, s_fgot);
    end
    step();
  endtask

  task automatic test_random();
    int busy_n, done_cyc, stim_bad, w, e_err, e_first, e_got;
    for (int it = 0; it < 8; it++) begin
      w = (it % 3 == 2) ? 1 : ((it % 2 == 0) ? 0 : 2);
      fill_resp(w, 2);
      run_sweep(w, busy_n, done_cyc, stim_bad);
      model(w, nvec(w), e_err, e_first, e_got);
      checks++;
      if (busy_n !== nvec(w) * per(w) || done_cyc !== nvec(w) * per(w) + 1 || stim_bad !== 0) begin
        errors++;
        $display("FAIL random%0d timing busy=%0d done=%0d stim_bad=%0d exp %0d/%0d/0",
                 it, busy_n, done_cyc, stim_bad, nvec(w) * per(w), nvec(w) * per(w) + 1);
      end
      check_results("random", w, nvec(w), int'(e_err == 0));
      step();
    end
  endtask

  task automatic test_abort();
    int busy_n, done_cyc, stim_bad, saw_done, k;
    fill_resp(1, 2);
    b_start = 1'b1; step(); b_start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    // Now at cycle 10; abort is seen on edge 11. Vector v is sampled on edge
    // 1 + per*(v+1), so only those before edge 11 count.
    b_abort = 1'b1; step(); b_abort = 1'b0;
    k = 0;
    for (int v = 0; v < 16; v++) if (1 + per(1) * (v + 1) < 11) k++;
    checks++;
    if (b_busy !== 1'b0 || b_stim !== 4'd0 || b_done !== 1'b0) begin
      errors++; $display("FAIL abort busy=%0d stim=%0d done=%0d exp 0/0/0", b_busy, b_stim, b_done);
    end
    check_results("abort_partial", 1, k, 0);
    saw_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (b_done === 1'b1 || b_busy === 1'b1) saw_done++;
      step();
    end
    checks++;
    if (saw_done !== 0) begin errors++; $display("FAIL abort_quiet active_cycles got=%0d exp=0", saw_done); end
    fill_resp(1, 0);
    run_sweep(1, busy_n, done_cyc, stim_bad);
    checks++;
    if (busy_n !== 64 || done_cyc !== 65 || stim_bad !== 0) begin
      errors++; $display("FAIL restart_after_abort busy=%0d done=%0d stim_bad=%0d exp 64/65/0", busy_n, done_cyc, stim_bad);
    end
    check_results("restart_after_abort", 1, 16, 1);
    step();
  endtask

  task automatic test_abort_last();
    // Vector 3 mismatches; aborting during its sample must discard it.
    fill_resp(0, 0);
    s_resp[3] = ~s_resp[3];
    s_start = 1'b1; step(); s_start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    s_abort = 1'b1; step(); s_abort = 1'b0;
    checks++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_stim !== 2'd0) begin
      errors++; $display("FAIL abort_last done=%0d busy=%0d stim=%0d exp 0/0/0", s_done, s_busy, s_stim);
    end
    check_results("abort_last", 0, 3, 0);
    step();
    checks++;
    if (s_done !== 1'b0) begin errors++; $display("FAIL abort_last_late_done got=%0d exp=0", s_done); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int n;
    fill_resp(0, 0);
    s_start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      step();
      if (s_done === 1'b1) q.push_back(c);
    end
    // First done on cycle 9; each sweep then needs the DONE cycle plus one
    // IDLE cycle in which start is sampled, giving a 10-cycle repeat.
    checks++;
    if (q.size() !== 20 || q[0] !== 9) begin
      errors++; $display("FAIL b2b done_count=%0d first=%0d exp 20/9", q.size(), (q.size() > 0) ? q[0] : -1);
    end
    for (int i = 1; i < q.size(); i++) begin
      checks++;
      if (q[i] - q[i-1] !== 10) begin
        errors++; $display("FAIL b2b spacing%0d got=%0d exp=10", i, q[i] - q[i-1]);
      end
    end
    n = 0;
    while (!(s_busy === 1'b1 && s_stim === 2'd1) && n < 20) begin step(); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL b2b wait_mid_sweep timed out after %0d cycles", n); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_busy, s_done, s_pass, s_err, s_fv, s_fvec, s_fgot, s_stim} !== '0) begin
      errors++; $display("FAIL async_reset busy=%0d done=%0d pass=%0d stim=%0d err=%0d exp all 0",
                         s_busy, s_done, s_pass, s_stim, s_err);
    end
    s_start = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step();
    step();
    checks++;
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_stim !== 2'd0) begin
      errors++; $display("FAIL post_reset busy=%0d done=%0d stim=%0d exp 0/0/0", s_busy, s_done, s_stim);
    end
  endtask

`ifdef TRUTH_SWEEP_SIG_EN
  task automatic test_sig();
    int busy_n, done_cyc, stim_bad;
    logic [15:0] exp_sig, first_sig;
    fill_resp(1, 0);
    exp_sig = crc_model(1);
    run_sweep(1, busy_n, done_cyc, stim_bad);
    first_sig = b_sig;
    checks++;
    if (b_sig !== exp_sig) begin errors++; $display("FAIL sig_sweep1 got=%h exp=%h", b_sig, exp_sig); end
    step();
    run_sweep(1, busy_n, done_cyc, stim_bad);
    checks++;
    if (b_sig !== first_sig || b_sig !== exp_sig) begin
      errors++; $display("FAIL sig_sweep2 got=%h exp=%h", b_sig, exp_sig);
    end
    step();
    fill_resp(2, 2);
    exp_sig = crc_model(2);
    run_sweep(2, busy_n, done_cyc, stim_bad);
    checks++;
    if (w_sig !== exp_sig) begin errors++; $display("FAIL sig_wide got=%h exp=%h", w_sig, exp_sig); end
    step();
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    s_start = 1'b0; s_abort = 1'b0;
    b_start = 1'b0; b_abort = 1'b0;
    w_start = 1'b0; w_abort = 1'b0;
    fill_resp(0, 0);
    fill_resp(1, 0);
    fill_resp(2, 0);
    #23 rst_n = 1'b1;
    step();
    test_reset();
    test_pass_sweep();
    test_stuck();
    test_random();
    test_abort();
    test_abort_last();
    test_back_to_back();
`ifdef TRUTH_SWEEP_SIG_EN
    test_sig();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
